// File: rtl/i2c_slave_read_byte.sv
// i2c_slave_read_byte
//   Byte assembler for the I2C slave receive path. Drives the bit reader
//   through its en/finish handshake DATA_WIDTH times, shifts the sampled bits
//   in MSB-first and reports the completed byte with a one-cycle finish pulse.
//   A bit-level error ends the byte early with finish+err and leaves the last
//   good byte on byte_read_o. Dropping byte_read_en mid-byte aborts silently.
module i2c_slave_read_byte #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_read_en,
  output logic [DATA_WIDTH-1:0] byte_read_o,
  output logic                  byte_read_err,
  output logic                  byte_read_finish,
  output logic                  bit_read_en,
  input  logic                  bit_read_o,
  input  logic                  bit_read_err,
  input  logic                  bit_read_finish
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] byte_q;
  logic                  err_q;
  logic                  finish_q;
  logic                  bit_en_q;

  // Next shift/count values when a good bit arrives.
  logic [DATA_WIDTH-1:0] shift_d;
  logic [CNT_W-1:0]      cnt_d;

  assign shift_d = {shift_q[DATA_WIDTH-2:0], bit_read_o};
  assign cnt_d   = cnt_q + CNT_W'(1);

  assign byte_read_o      = byte_q;
  assign byte_read_err    = err_q;
  assign byte_read_finish = finish_q;
  assign bit_read_en      = bit_en_q;

  // Byte sequencer: FSM, shift register, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      byte_q   <= '0;
      err_q    <= 1'b0;
      finish_q <= 1'b0;
      bit_en_q <= 1'b0;
    end else begin
      // finish/err are single-cycle pulses; only the REQ->DONE transition sets them.
      finish_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          shift_q <= '0;
          cnt_q   <= '0;
          if (byte_read_en) begin
            state_q  <= ST_REQ;
            bit_en_q <= 1'b1;
          end else begin
            state_q  <= ST_IDLE;
            bit_en_q <= 1'b0;
          end
        end

        ST_REQ: begin
          if (!byte_read_en) begin
            // Caller withdrew the request: abandon the byte without a pulse.
            state_q  <= ST_IDLE;
            bit_en_q <= 1'b0;
          end else if (bit_read_finish) begin
            bit_en_q <= 1'b0;
            if (bit_read_err) begin
              // byte_q deliberately keeps the last good byte.
              state_q  <= ST_DONE;
              finish_q <= 1'b1;
              err_q    <= 1'b1;
            end else begin
              shift_q <= shift_d;
              cnt_q   <= cnt_d;
              if (cnt_q == LAST_BIT) begin
                state_q  <= ST_DONE;
                finish_q <= 1'b1;
                byte_q   <= shift_d;
              end else begin
                state_q <= ST_GAP;
              end
            end
          end else begin
            state_q  <= ST_REQ;
            bit_en_q <= 1'b1;
          end
        end

        ST_GAP: begin
          // One low cycle so the bit reader sees a fresh request edge.
          if (!byte_read_en) begin
            state_q  <= ST_IDLE;
            bit_en_q <= 1'b0;
          end else begin
            state_q  <= ST_REQ;
            bit_en_q <= 1'b1;
          end
        end

        ST_DONE: begin
          state_q  <= ST_IDLE;
          bit_en_q <= 1'b0;
        end

        default: begin
          state_q  <= ST_IDLE;
          bit_en_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_read_byte.sv
// Testbench for i2c_slave_read_byte: behavioural bit reader with programmable
// latency, scoreboard of expected bytes, table of byte reads plus hand-written
// abort and reset sequences.
module tb_i2c_slave_read_byte;

  logic       clk = 1'b0;
  logic       rst;
  logic       byte_read_en;
  logic [7:0] byte_read_o;
  logic       byte_read_err;
  logic       byte_read_finish;
  logic       bit_read_en;
  logic       bit_read_o;
  logic       bit_read_err;
  logic       bit_read_finish;

  i2c_slave_read_byte #(.DATA_WIDTH(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .byte_read_en     (byte_read_en),
    .byte_read_o      (byte_read_o),
    .byte_read_err    (byte_read_err),
    .byte_read_finish (byte_read_finish),
    .bit_read_en      (bit_read_en),
    .bit_read_o       (bit_read_o),
    .bit_read_err     (bit_read_err),
    .bit_read_finish  (bit_read_finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    int         err_pos;   // 0: no error, else 1-based bit that reports an error
    bit         hold;      // keep byte_read_en high after finish (back-to-back)
    logic [7:0] exp_byte;
    logic       exp_err;
    int         lat_hi;
  } vec_t;

  exp_t sb[$];
  bit   bitq[$];
  bit   errq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_rise  = 0;
  int finish_cnt = 0;
  int low_run = 0;
  int lat_lo = 1;
  int lat_hi = 1;
  int cd = 0;
  bit pend = 1'b0;
  bit en_prev = 1'b0;
  bit in_byte = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: observe DUT after the edge, then update the bit-reader model.
  task automatic step();
    exp_t e;
    bit   rise;
    int   lat;
    @(posedge clk);
    #1;
    if (byte_read_finish === 1'b1) begin
      finish_cnt++;
      in_byte = 1'b0;
      if (sb.size() == 0) begin
        check("unexpected_finish", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("byte_value", {24'd0, byte_read_o}, {24'd0, e.data});
        check("byte_err", {31'd0, byte_read_err}, {31'd0, e.err});
      end
    end else if (byte_read_err === 1'b1) begin
      check("err_without_finish", 32'd1, 32'd0);
    end
    rise = (bit_read_en === 1'b1) && !en_prev;
    if (rise) begin
      n_rise++;
      if (in_byte) check("gap_len", low_run, 32'd1);
      in_byte = 1'b1;
    end
    low_run = (bit_read_en === 1'b1) ? 0 : low_run + 1;

    bit_read_finish = 1'b0;
    bit_read_o      = 1'b0;
    bit_read_err    = 1'b0;
    if (bit_read_en !== 1'b1) pend = 1'b0;
    if (rise) begin
      lat  = int'($urandom_range(lat_hi, lat_lo));
      pend = 1'b1;
      cd   = lat - 1;
    end else if (pend) begin
      cd = cd - 1;
    end
    if (pend && cd == 0) begin
      pend = 1'b0;
      bit_read_finish = 1'b1;
      if (bitq.size() == 0) begin
        check("model_underrun", 32'd1, 32'd0);
      end else begin
        bit_read_o   = bitq.pop_front();
        bit_read_err = errq.pop_front();
      end
    end
    en_prev = (bit_read_en === 1'b1);
  endtask

  task automatic wait_finish(input int target);
    int n = 0;
    while (finish_cnt < target && n < 600) begin
      step();
      n++;
    end
    if (finish_cnt < target) check("finish_timeout", finish_cnt, target);
  endtask

  task automatic wait_rise(input int target);
    int n = 0;
    while (n_rise < target && n < 200) begin
      step();
      n++;
    end
    if (n_rise < target) check("rise_timeout", n_rise, target);
  endtask

  task automatic feed(input logic [7:0] d, input int err_pos);
    int nb;
    nb = (err_pos > 0) ? err_pos : 8;
    for (int i = 0; i < nb; i++) begin
      bitq.push_back(d[7-i]);
      errq.push_back((i == err_pos - 1) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   r0;
    int   tgt;
    r0  = n_rise;
    tgt = finish_cnt + 1;
    lat_lo = 1;
    lat_hi = v.lat_hi;
    feed(v.data, v.err_pos);
    e.data = v.exp_byte;
    e.err  = v.exp_err;
    sb.push_back(e);
    byte_read_en = 1'b1;
    wait_finish(tgt);
    check("rise_count", n_rise - r0, (v.err_pos > 0) ? v.err_pos : 8);
    if (!v.hold) byte_read_en = 1'b0;
  endtask

  task automatic clear_model();
    bitq.delete();
    errq.delete();
    in_byte = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    vec_t v;
    int   r0;
    int   f0;
    tbl[0] = '{data: 8'hA5, err_pos: 0, hold: 1'b0, exp_byte: 8'hA5, exp_err: 1'b0, lat_hi: 1};
    tbl[1] = '{data: 8'h00, err_pos: 0, hold: 1'b1, exp_byte: 8'h00, exp_err: 1'b0, lat_hi: 2};
    tbl[2] = '{data: 8'hFF, err_pos: 0, hold: 1'b0, exp_byte: 8'hFF, exp_err: 1'b0, lat_hi: 2};
    tbl[3] = '{data: 8'h3C, err_pos: 0, hold: 1'b1, exp_byte: 8'h3C, exp_err: 1'b0, lat_hi: 3};
    tbl[4] = '{data: 8'h5A, err_pos: 4, hold: 1'b0, exp_byte: 8'h3C, exp_err: 1'b1, lat_hi: 3};
    tbl[5] = '{data: 8'h81, err_pos: 0, hold: 1'b0, exp_byte: 8'h81, exp_err: 1'b0, lat_hi: 4};

    rst             = 1'b1;
    byte_read_en    = 1'b0;
    bit_read_o      = 1'b0;
    bit_read_err    = 1'b0;
    bit_read_finish = 1'b0;
    step();
    step();
    check("rst_bit_en", {31'd0, bit_read_en}, 32'd0);
    check("rst_finish", {31'd0, byte_read_finish}, 32'd0);
    check("rst_err", {31'd0, byte_read_err}, 32'd0);
    check("rst_byte", {24'd0, byte_read_o}, 32'd0);
    rst = 1'b0;
    step();
    check("idle_bit_en", {31'd0, bit_read_en}, 32'd0);

    // Table of complete byte reads, including back-to-back and a bit error.
    for (int i = 0; i < 6; i++) begin
      v = tbl[i];
      run_vec(v);
      if (v.exp_err) begin
        check("err_bit_en_low", {31'd0, bit_read_en}, 32'd0);
        clear_model();
        step();
        step();
        check("err_idle_bit_en", {31'd0, bit_read_en}, 32'd0);
        check("err_idle_finish", {31'd0, byte_read_finish}, 32'd0);
        check("err_hold_byte", {24'd0, byte_read_o}, 32'h3C);
      end
    end
    for (int i = 0; i < 3; i++) step();

    // Abort: drop byte_read_en while bit 6 is being requested.
    lat_lo = 6;
    lat_hi = 6;
    feed(8'hC6, 0);
    r0 = n_rise;
    f0 = finish_cnt;
    byte_read_en = 1'b1;
    wait_rise(r0 + 6);
    byte_read_en = 1'b0;
    step();
    check("abort_bit_en_fall", {31'd0, bit_read_en}, 32'd0);
    for (int i = 0; i < 6; i++) step();
    check("abort_no_finish", finish_cnt, f0);
    check("abort_byte_hold", {24'd0, byte_read_o}, 32'h81);
    clear_model();
    v = '{data: 8'h13, err_pos: 0, hold: 1'b0, exp_byte: 8'h13, exp_err: 1'b0, lat_hi: 3};
    run_vec(v);
    step();

    // Synchronous reset during bit 3.
    lat_lo = 6;
    lat_hi = 6;
    feed(8'h99, 0);
    r0 = n_rise;
    f0 = finish_cnt;
    byte_read_en = 1'b1;
    wait_rise(r0 + 3);
    rst = 1'b1;
    byte_read_en = 1'b0;
    step();
    rst = 1'b0;
    check("midrst_bit_en", {31'd0, bit_read_en}, 32'd0);
    check("midrst_finish", {31'd0, byte_read_finish}, 32'd0);
    check("midrst_err", {31'd0, byte_read_err}, 32'd0);
    check("midrst_byte", {24'd0, byte_read_o}, 32'd0);
    step();
    check("midrst_no_finish", finish_cnt, f0);
    clear_model();
    v = '{data: 8'h57, err_pos: 0, hold: 1'b0, exp_byte: 8'h57, exp_err: 1'b0, lat_hi: 2};
    run_vec(v);
    step();

    // 32 back-to-back bytes with bit-reader latencies of 1..20 cycles.
    for (int i = 0; i < 32; i++) begin
      v.data     = 8'h13 + 8'(i) * 8'h44;
      v.err_pos  = 0;
      v.hold     = (i != 31);
      v.exp_byte = v.data;
      v.exp_err  = 1'b0;
      v.lat_hi   = 20;
      run_vec(v);
    end
    for (int i = 0; i < 4; i++) step();
    check("scoreboard_empty", sb.size(), 32'd0);
    check("final_bit_en", {31'd0, bit_read_en}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
